vga_timing_scanout: RTL and testbench

- Drives the physical VGA port and generates the scan coordinates that the renderer (vga_handler) consumes.
- Free-running horizontal and vertical counters produce x/y for the renderer.
- The returned RRRGGGBB pixel_color is sampled after a fixed pipeline delay and expanded to 8-bit R/G/B for the DAC.
- hsync, vsync and blank are delayed by the same amount so they stay aligned with the colour data.
- It also emits frame and vblank strobes for game logic (character position and state updates).

---
 rtl/vga_timing_scanout.sv | 203 ++++++++++++++++++++
 tb/tb_vga_timing_scanout.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_scanout.sv
// -----------------------------------------------------------------------------
// vga_timing_scanout
//
// Produces the VGA raster. Free-running horizontal and vertical counters give
// the renderer its scan coordinates. The renderer's RRRGGGBB colour comes back
// PIPE_DELAY cycles later. The active-area and sync flags are delayed by the
// same amount, so one output register can capture colour and flags together.
// The registered colour is expanded to 8 bits per channel for the DAC.
//
// Ports
//   vga_clk       pixel clock; the only clock
//   rst           asynchronous, active-high reset
//   pixel_color   RRRGGGBB from the renderer, valid PIPE_DELAY cycles after x/y
//   x, y          current horizontal / vertical count, fed to the renderer
//   video_on      undelayed active-area flag, aligned with x/y
//   frame_start   one-cycle strobe at (0,0), undelayed
//   vblank_start  one-cycle strobe at (0,V_ACTIVE), undelayed
//   vga_r/g/b     8-bit colour to the DAC, zero outside the active area
//   vga_hs/vs     sync pulses at level SYNC_ACTIVE
//   vga_blank_n   low outside the active area
//
// The outputs for the coordinate presented in cycle n appear in cycle
// n + PIPE_DELAY + 1.
// -----------------------------------------------------------------------------
module vga_timing_scanout #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter int   PIPE_DELAY  = 2,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic [7:0] pixel_color,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_C    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // ---------------------------------------------------------------------------
  // Scan counters
  // ---------------------------------------------------------------------------
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    // The vertical count moves only on the edge where the line wraps. At the
    // last line, both counters return to zero on that same edge.
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Undelayed flags (internally active-high regardless of SYNC_ACTIVE)
  // ---------------------------------------------------------------------------
  logic vid_raw;
  logic hs_raw;
  logic vs_raw;

  always_comb begin
    vid_raw      = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hs_raw       = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    vs_raw       = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
    frame_start  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    vblank_start = (h_cnt_q == 10'd0) && (v_cnt_q == V_ACT_C);
  end

  assign x        = h_cnt_q;
  assign y        = v_cnt_q;
  assign video_on = vid_raw;

  // ---------------------------------------------------------------------------
  // Flag delay line: {video_on, hs, vs}, matched to the renderer latency.
  // All stages clear to "inactive", so no sync pulse or colour can come out of
  // the pipe while it refills after reset.
  // ---------------------------------------------------------------------------
  logic [2:0] flags_raw;
  logic [2:0] flags_dly;

  assign flags_raw = {vid_raw, hs_raw, vs_raw};

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign flags_dly = flags_raw;
    end else begin : g_pipe
      logic [2:0] stage_q [PIPE_DELAY];
      logic [2:0] stage_d [PIPE_DELAY];

      always_comb begin
        stage_d[0] = flags_raw;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            stage_q[i] <= 3'b000;
          end
        end else begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign flags_dly = stage_q[PIPE_DELAY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output register: captures pixel_color together with the delayed flags.
  // Colour expansion replicates the MSBs into the low bits, so full-scale
  // inputs map to 8'hFF and zero maps to zero.
  // ---------------------------------------------------------------------------
  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;
  logic [7:0] b_q, b_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_n_q, blank_n_d;

  always_comb begin
    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
    if (flags_dly[2]) begin
      r_d = {pixel_color[7:5], pixel_color[7:5], pixel_color[7:6]};
      g_d = {pixel_color[4:2], pixel_color[4:2], pixel_color[4:3]};
      b_d = {4{pixel_color[1:0]}};
    end
    hs_d      = flags_dly[1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_d      = flags_dly[0] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    blank_n_d = flags_dly[2];
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
      hs_q      <= ~SYNC_ACTIVE;
      vs_q      <= ~SYNC_ACTIVE;
      blank_n_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;

endmodule

// File: tb/tb_vga_timing_scanout.sv
// -----------------------------------------------------------------------------
// Testbench for vga_timing_scanout.
//
// Three builds are instantiated:
//   unit 0: full 640x480 timing, PIPE_DELAY=2, active-low sync
//   unit 1: reduced 16x12 raster (32x19 total), PIPE_DELAY=2, active-low sync
//   unit 2: reduced 16x12 raster, PIPE_DELAY=0, active-high sync
// The reduced rasters keep whole-frame scenarios short. A renderer model per
// unit returns pixel_color with that unit's latency. Expected outputs are
// pushed to a queue when a coordinate is presented, and are popped when the
// DUT is due to show them.
// -----------------------------------------------------------------------------
module tb_vga_timing_scanout;

  localparam int HA  [3] = '{640, 16, 16};
  localparam int HFP [3] = '{16, 4, 4};
  localparam int HSY [3] = '{96, 6, 6};
  localparam int HBP [3] = '{48, 6, 6};
  localparam int VA  [3] = '{480, 12, 12};
  localparam int VFP [3] = '{10, 2, 2};
  localparam int VSY [3] = '{2, 2, 2};
  localparam int VBP [3] = '{33, 3, 3};
  localparam int PD  [3] = '{2, 2, 0};
  localparam int SA  [3] = '{0, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_s = 1'b1, rst_z = 1'b1;
  logic mode_echo = 1'b0;
  logic [7:0] const_col = 8'h00;

  logic [7:0] pc_a, pc_s, pc_z;
  logic [9:0] x_a, y_a, x_s, y_s, x_z, y_z;
  logic vo_a, fs_a, vb_a, vo_s, fs_s, vb_s, vo_z, fs_z, vb_z;
  logic [7:0] r_a, g_a, b_a, r_s, g_s, b_s, r_z, g_z, b_z;
  logic hs_a, vs_a, bn_a, hs_s, vs_s, bn_s, hs_z, vs_z, bn_z;

  vga_timing_scanout #(
    .H_ACTIVE(HA[0]), .H_FP(HFP[0]), .H_SYNC(HSY[0]), .H_BP(HBP[0]),
    .V_ACTIVE(VA[0]), .V_FP(VFP[0]), .V_SYNC(VSY[0]), .V_BP(VBP[0]),
    .PIPE_DELAY(PD[0]), .SYNC_ACTIVE(SA[0] != 0)
  ) u_dut_a (
    .vga_clk(clk), .rst(rst_a), .pixel_color(pc_a), .x(x_a), .y(y_a),
    .video_on(vo_a), .frame_start(fs_a), .vblank_start(vb_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
    .vga_blank_n(bn_a)
  );

  vga_timing_scanout #(
    .H_ACTIVE(HA[1]), .H_FP(HFP[1]), .H_SYNC(HSY[1]), .H_BP(HBP[1]),
    .V_ACTIVE(VA[1]), .V_FP(VFP[1]), .V_SYNC(VSY[1]), .V_BP(VBP[1]),
    .PIPE_DELAY(PD[1]), .SYNC_ACTIVE(SA[1] != 0)
  ) u_dut_s (
    .vga_clk(clk), .rst(rst_s), .pixel_color(pc_s), .x(x_s), .y(y_s),
    .video_on(vo_s), .frame_start(fs_s), .vblank_start(vb_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .vga_hs(hs_s), .vga_vs(vs_s),
    .vga_blank_n(bn_s)
  );

  vga_timing_scanout #(
    .H_ACTIVE(HA[2]), .H_FP(HFP[2]), .H_SYNC(HSY[2]), .H_BP(HBP[2]),
    .V_ACTIVE(VA[2]), .V_FP(VFP[2]), .V_SYNC(VSY[2]), .V_BP(VBP[2]),
    .PIPE_DELAY(PD[2]), .SYNC_ACTIVE(SA[2] != 0)
  ) u_dut_z (
    .vga_clk(clk), .rst(rst_z), .pixel_color(pc_z), .x(x_z), .y(y_z),
    .video_on(vo_z), .frame_start(fs_z), .vblank_start(vb_z),
    .vga_r(r_z), .vga_g(g_z), .vga_b(b_z), .vga_hs(hs_z), .vga_vs(vs_z),
    .vga_blank_n(bn_z)
  );

  // Renderer models: two-cycle latency for units 0/1, combinational for unit 2.
  logic [7:0] ren_a1, ren_a2, ren_s1, ren_s2;
  always_ff @(posedge clk) begin
    ren_a1 <= mode_echo ? x_a[7:0] : const_col;
    ren_a2 <= ren_a1;
    ren_s1 <= mode_echo ? x_s[7:0] : const_col;
    ren_s2 <= ren_s1;
  end
  assign pc_a = ren_a2;
  assign pc_s = ren_s2;
  assign pc_z = mode_echo ? x_z[7:0] : const_col;

  // Scoreboard and raster model state
  int n_cmp = 0;
  int n_bad = 0;
  int mh, mv;
  logic [26:0] sb_q[$];
  logic [26:0] exp_o;

  function automatic int ht(input int u);
    return HA[u] + HFP[u] + HSY[u] + HBP[u];
  endfunction

  function automatic int vt(input int u);
    return VA[u] + VFP[u] + VSY[u] + VBP[u];
  endfunction

  function automatic logic [26:0] obs(input int u);
    case (u)
      0:       return {r_a, g_a, b_a, hs_a, vs_a, bn_a};
      1:       return {r_s, g_s, b_s, hs_s, vs_s, bn_s};
      default: return {r_z, g_z, b_z, hs_z, vs_z, bn_z};
    endcase
  endfunction

  function automatic logic [19:0] coords(input int u);
    case (u)
      0:       return {x_a, y_a};
      1:       return {x_s, y_s};
      default: return {x_z, y_z};
    endcase
  endfunction

  // {video_on, frame_start, vblank_start}
  function automatic logic [2:0] strobes(input int u);
    case (u)
      0:       return {vo_a, fs_a, vb_a};
      1:       return {vo_s, fs_s, vb_s};
      default: return {vo_z, fs_z, vb_z};
    endcase
  endfunction

  // Output word shown while the pipe holds no valid coordinate.
  function automatic logic [26:0] idle_out(input int u);
    logic inact;
    inact = (SA[u] == 0);
    return {24'h0, inact, inact, 1'b0};
  endfunction

  // Expected DAC/sync word for coordinate (h,v) carrying colour c.
  function automatic logic [26:0] model_out(input int u, input int h, input int v,
                                            input logic [7:0] c);
    logic vid, hsr, vsr, hs, vs;
    logic [9:0] r9, g9;
    logic [7:0] r, g, b;
    vid = (h < HA[u]) && (v < VA[u]);
    hsr = (h >= HA[u] + HFP[u]) && (h < HA[u] + HFP[u] + HSY[u]);
    vsr = (v >= VA[u] + VFP[u]) && (v < VA[u] + VFP[u] + VSY[u]);
    r9  = 10'(c[7:5]) * 10'd73;   // three copies of the 3-bit field
    g9  = 10'(c[4:2]) * 10'd73;
    r   = vid ? r9[8:1] : 8'h00;
    g   = vid ? g9[8:1] : 8'h00;
    b   = vid ? 8'(c[1:0]) * 8'h55 : 8'h00;
    hs  = (hsr == (SA[u] != 0));
    vs  = (vsr == (SA[u] != 0));
    return {r, g, b, hs, vs, vid};
  endfunction

  task automatic set_rst(input int u, input logic v);
    case (u)
      0:       rst_a = v;
      1:       rst_s = v;
      default: rst_z = v;
    endcase
  endtask

  task automatic push_cur(input int u);
    logic [7:0] c;
    c = mode_echo ? 8'(mh) : const_col;
    sb_q.push_back(model_out(u, mh, mv, c));
    exp_o = sb_q.pop_front();
  endtask

  task automatic advance(input int u);
    @(posedge clk);
    #1;
    if (mh == ht(u) - 1) begin
      mh = 0;
      mv = (mv == vt(u) - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    push_cur(u);
  endtask

  task automatic hold_reset(input int u, input int n);
    set_rst(u, 1'b1);
    repeat (n) @(posedge clk);
  endtask

  // Releases reset just after an edge; the current cycle becomes cycle 0.
  task automatic release_reset(input int u);
    @(posedge clk);
    #1;
    set_rst(u, 1'b0);
    mh = 0;
    mv = 0;
    sb_q.delete();
    for (int i = 0; i <= PD[u]; i++) sb_q.push_back(idle_out(u));
    push_cur(u);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int rise_k;
    const_col = 8'hFF;
    mode_echo = 1'b0;
    set_rst(0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs(0) !== idle_out(0)) begin
        n_bad++;
        $display("FAIL rst_outputs: got %h expected %h", obs(0), idle_out(0));
      end
      n_cmp++;
      if ({coords(0), strobes(0)} !== {20'h0, 3'b110}) begin
        n_bad++;
        $display("FAIL rst_coords: got %h expected %h", {coords(0), strobes(0)}, {20'h0, 3'b110});
      end
    end
    release_reset(0);
    n_cmp++;
    if (strobes(0) !== 3'b110) begin
      n_bad++;
      $display("FAIL first_frame_start: got %b expected %b", strobes(0), 3'b110);
    end
    rise_k = -1;
    for (int k = 1; k <= 20; k++) begin
      advance(0);
      if (k == 1) begin
        n_cmp++;
        if (coords(0) !== {10'd1, 10'd0}) begin
          n_bad++;
          $display("FAIL first_edge_xy: got %h expected %h", coords(0), {10'd1, 10'd0});
        end
      end
      if (bn_a === 1'b1 && rise_k < 0) rise_k = k;
    end
    n_cmp++;
    if (rise_k != PD[0] + 1) begin
      n_bad++;
      $display("FAIL blank_rise_delay: got %0d expected %0d", rise_k, PD[0] + 1);
    end
  endtask

  task automatic test_hsync_lines();
    int last_x0, fall_at;
    logic prev_hs;
    logic [23:0] want_rgb;
    hold_reset(0, 2);
    mode_echo = 1'b0;
    const_col = 8'b101_010_11;
    release_reset(0);
    last_x0 = -1;
    fall_at = -1;
    prev_hs = 1'b1;
    for (int k = 0; k < 1700; k++) begin
      if (k > 0) advance(0);
      if (k == 780) const_col = 8'hFF;   // changed inside horizontal blanking
      n_cmp++;
      if (obs(0) !== exp_o) begin
        n_bad++;
        $display("FAIL line_sb k=%0d: got %h expected %h", k, obs(0), exp_o);
      end
      n_cmp++;
      if (coords(0) !== {10'(mh), 10'(mv)}) begin
        n_bad++;
        $display("FAIL line_xy k=%0d: got %h expected %h", k, coords(0), {10'(mh), 10'(mv)});
      end
      want_rgb = (k - PD[0] - 1 < 800) ? 24'hB6_49_FF : 24'hFF_FF_FF;
      n_cmp++;
      if (bn_a === 1'b1) begin
        if ({r_a, g_a, b_a} !== want_rgb) begin
          n_bad++;
          $display("FAIL rgb_active k=%0d: got %h expected %h", k, {r_a, g_a, b_a}, want_rgb);
        end
      end else if ({r_a, g_a, b_a} !== 24'h0) begin
        n_bad++;
        $display("FAIL rgb_blank k=%0d: got %h expected 0", k, {r_a, g_a, b_a});
      end
      if (prev_hs === 1'b1 && hs_a === 1'b0) begin
        fall_at = k;
        n_cmp++;
        if (k - last_x0 != 656 + PD[0] + 1) begin
          n_bad++;
          $display("FAIL hs_start: got %0d expected %0d", k - last_x0, 656 + PD[0] + 1);
        end
      end
      if (prev_hs === 1'b0 && hs_a === 1'b1) begin
        n_cmp++;
        if (k - fall_at != 96) begin
          n_bad++;
          $display("FAIL hs_width: got %0d expected 96", k - fall_at);
        end
      end
      prev_hs = hs_a;
      if (x_a === 10'd0) begin
        if (last_x0 >= 0) begin
          n_cmp++;
          if (k - last_x0 != 800) begin
            n_bad++;
            $display("FAIL line_period: got %0d expected 800", k - last_x0);
          end
        end
        last_x0 = k;
      end
    end
  endtask

  task automatic test_echo();
    hold_reset(0, 2);
    mode_echo = 1'b1;
    release_reset(0);
    for (int k = 0; k < 820; k++) begin
      if (k > 0) advance(0);
      n_cmp++;
      if (obs(0) !== exp_o) begin
        n_bad++;
        $display("FAIL echo_sb k=%0d: got %h expected %h", k, obs(0), exp_o);
      end
      if (k == PD[0] + 1 || k == PD[0] + 6 || k == PD[0] + 640 || k == PD[0] + 641) begin
        logic [24:0] want;
        case (k - PD[0] - 1)
          0:       want = {24'h00_00_00, 1'b1};
          5:       want = {24'h00_24_55, 1'b1};
          639:     want = {24'h6D_FF_FF, 1'b1};
          default: want = 25'h0;
        endcase
        n_cmp++;
        if ({r_a, g_a, b_a, bn_a} !== want) begin
          n_bad++;
          $display("FAIL echo_x%0d: got %h expected %h", k - PD[0] - 1, {r_a, g_a, b_a, bn_a}, want);
        end
      end
    end
  endtask

  task automatic test_frame();
    int last_fs, fs_seen, vb_seen, vs_fall;
    logic prev_vs;
    logic [2:0] want_st;
    hold_reset(1, 2);
    mode_echo = 1'b1;
    release_reset(1);
    last_fs = -1; fs_seen = 0; vb_seen = 0; vs_fall = -1; prev_vs = 1'b1;
    for (int k = 0; k < 2 * 608 + 10; k++) begin
      if (k > 0) advance(1);
      n_cmp++;
      if (obs(1) !== exp_o) begin
        n_bad++;
        $display("FAIL frame_sb k=%0d: got %h expected %h", k, obs(1), exp_o);
      end
      want_st = {(mh < HA[1]) && (mv < VA[1]), (mh == 0) && (mv == 0), (mh == 0) && (mv == VA[1])};
      n_cmp++;
      if (strobes(1) !== want_st) begin
        n_bad++;
        $display("FAIL frame_strobes k=%0d: got %b expected %b", k, strobes(1), want_st);
      end
      if (fs_s === 1'b1) begin
        fs_seen++;
        if (last_fs >= 0) begin
          n_cmp++;
          if (k - last_fs != 608) begin
            n_bad++;
            $display("FAIL frame_period: got %0d expected 608", k - last_fs);
          end
        end
        last_fs = k;
      end
      if (vb_s === 1'b1) begin
        vb_seen++;
        n_cmp++;
        if (coords(1) !== {10'd0, 10'd12}) begin
          n_bad++;
          $display("FAIL vblank_pos: got %h expected %h", coords(1), {10'd0, 10'd12});
        end
      end
      if (prev_vs === 1'b1 && vs_s === 1'b0) vs_fall = k;
      if (prev_vs === 1'b0 && vs_s === 1'b1) begin
        n_cmp++;
        if (k - vs_fall != 64) begin
          n_bad++;
          $display("FAIL vs_width: got %0d expected 64", k - vs_fall);
        end
      end
      prev_vs = vs_s;
    end
    n_cmp++;
    if (fs_seen != 3 || vb_seen != 2) begin
      n_bad++;
      $display("FAIL strobe_count: got fs=%0d vb=%0d expected fs=3 vb=2", fs_seen, vb_seen);
    end
  endtask

  task automatic test_mid_reset();
    bit reached;
    hold_reset(1, 2);
    mode_echo = 1'b1;
    release_reset(1);
    reached = 1'b0;
    for (int k = 0; k < 700 && !reached; k++) begin
      advance(1);
      if (mh == 9 && mv == 5) reached = 1'b1;
    end
    n_cmp++;
    if (coords(1) !== {10'd9, 10'd5}) begin
      n_bad++;
      $display("FAIL midrst_reach: got %h expected %h", coords(1), {10'd9, 10'd5});
    end
    #3;
    set_rst(1, 1'b1);
    #1;
    n_cmp++;
    if (obs(1) !== idle_out(1)) begin
      n_bad++;
      $display("FAIL midrst_async: got %h expected %h", obs(1), idle_out(1));
    end
    n_cmp++;
    if ({coords(1), strobes(1)} !== {20'h0, 3'b110}) begin
      n_bad++;
      $display("FAIL midrst_coords: got %h expected %h", {coords(1), strobes(1)}, {20'h0, 3'b110});
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs(1) !== idle_out(1)) begin
        n_bad++;
        $display("FAIL midrst_hold: got %h expected %h", obs(1), idle_out(1));
      end
    end
    release_reset(1);
    for (int k = 0; k < 700; k++) begin
      if (k > 0) advance(1);
      n_cmp++;
      if (obs(1) !== exp_o || coords(1) !== {10'(mh), 10'(mv)}) begin
        n_bad++;
        $display("FAIL midrst_sb k=%0d: got %h/%h expected %h/%h", k, obs(1), coords(1),
                 exp_o, {10'(mh), 10'(mv)});
      end
      if (k < HA[1] + HFP[1] + PD[1] + 1) begin
        n_cmp++;
        if (hs_s !== 1'b1 || vs_s !== 1'b1) begin
          n_bad++;
          $display("FAIL no_runt k=%0d: got hs=%b vs=%b expected 1/1", k, hs_s, vs_s);
        end
      end
    end
  endtask

  task automatic test_pd0();
    logic [25:0] want;
    hold_reset(2, 2);
    mode_echo = 1'b1;
    release_reset(2);
    for (int k = 0; k < 2 * 608 + 5; k++) begin
      if (k > 0) advance(2);
      n_cmp++;
      if (obs(2) !== exp_o || coords(2) !== {10'(mh), 10'(mv)}) begin
        n_bad++;
        $display("FAIL pd0_sb k=%0d: got %h/%h expected %h/%h", k, obs(2), coords(2),
                 exp_o, {10'(mh), 10'(mv)});
      end
      if (k == 0 || k == 1 || k == 6 || k == 16 || k == 17 || k == 21) begin
        // {rgb, hs, blank_n}; outputs trail the coordinate by one cycle
        case (k)
          0:       want = {24'h00_00_00, 1'b0, 1'b0};
          1:       want = {24'h00_00_00, 1'b0, 1'b1};
          6:       want = {24'h00_24_55, 1'b0, 1'b1};
          16:      want = {24'h00_6D_FF, 1'b0, 1'b1};
          17:      want = {24'h00_00_00, 1'b0, 1'b0};
          default: want = {24'h00_00_00, 1'b1, 1'b0};
        endcase
        n_cmp++;
        if ({r_z, g_z, b_z, hs_z, bn_z} !== want) begin
          n_bad++;
          $display("FAIL pd0_k%0d: got %h expected %h", k, {r_z, g_z, b_z, hs_z, bn_z}, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hsync_lines();
    test_echo();
    test_frame();
    test_mid_reset();
    test_pd0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
